// File: rtl/npu_pkg.sv
// Shared NPU types and widths: MAC sequencer states, accumulator/data widths,
// and the length/address widths shared with the command register block.
package npu_pkg;

   localparam int ACC_W      = 32;
   localparam int DATA_W     = 8;
   localparam int NPU_ADDR_W = 10;
   localparam int NPU_LEN_W  = 10;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      RUN,
      DRAIN,
      DONE
   } mac_seq_state_e;

   // Clamp negative accumulator values to zero.
   function automatic logic signed [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] v);
      return v[ACC_W-1] ? '0 : v;
   endfunction

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Job/result handshake bundle between the NPU command registers (master)
// and the MAC sequencer (slave).
interface mac_seq_ctrl_if
   import npu_pkg::*;
#(
   parameter int ADDR_W = NPU_ADDR_W,
   parameter int LEN_W  = NPU_LEN_W
);

   logic                    start_valid;
   logic                    start_ready;
   logic [LEN_W-1:0]        cfg_len;
   logic [ADDR_W-1:0]       cfg_w_base;
   logic [ADDR_W-1:0]       cfg_a_base;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [ACC_W-1:0] out_data;

   modport master (
      output start_valid, cfg_len, cfg_w_base, cfg_a_base, out_ready,
      input  start_ready, out_valid, out_data
   );

   modport slave (
      input  start_valid, cfg_len, cfg_w_base, cfg_a_base, out_ready,
      output start_ready, out_valid, out_data
   );

endinterface

// File: rtl/mac_seq_addr_gen.sv
// SRAM address generator: loads a base, steps by one with modulo-2^ADDR_W wrap.
// Address holds whenever neither load nor step is asserted.
module mac_seq_addr_gen #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] base,
   input  logic              step,
   output logic [ADDR_W-1:0] addr
);

   logic [ADDR_W-1:0] addr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q <= '0;
      end else if (load) begin
         addr_q <= base;
      end else if (step) begin
         addr_q <= addr_q + ADDR_W'(1);
      end
   end

   assign addr = addr_q;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer for one INT8 MAC: result valid len+2 cycles after accept (2 for len=0),
// held until out_ready; no new job accepted while busy. MAC_SEQ_RELU_EN clamps negative results to 0.
module mac_seq_ctrl
   import npu_pkg::*;
#(
   parameter int ADDR_W = NPU_ADDR_W,
   parameter int LEN_W  = NPU_LEN_W
) (
   input  logic                    clk,
   input  logic                    rst,
   mac_seq_ctrl_if.slave           job,
   output logic                    w_rd_en,
   output logic [ADDR_W-1:0]       w_rd_addr,
   output logic                    a_rd_en,
   output logic [ADDR_W-1:0]       a_rd_addr,
   output logic                    mac_clear,
   output logic                    mac_enable,
   input  logic signed [ACC_W-1:0] mac_result,
   output logic                    busy
);

   mac_seq_state_e state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] idx_q, idx_d;
   logic             addr_load;
   logic             addr_step;
   logic             rd_en;
   logic             start_ready;
   logic             out_valid;
   logic signed [ACC_W-1:0] result_view;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         len_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
      end
   end

   // idx_q is the index whose read is issued in the current cycle.
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      idx_d       = idx_q;
      start_ready = 1'b0;
      rd_en       = 1'b0;
      addr_load   = 1'b0;
      addr_step   = 1'b0;
      mac_clear   = 1'b0;
      mac_enable  = 1'b0;
      out_valid   = 1'b0;

      unique case (state_q)
         IDLE: begin
            start_ready = 1'b1;
            if (job.start_valid) begin
               len_d     = job.cfg_len;
               idx_d     = '0;
               addr_load = 1'b1;
               state_d   = CLEAR;
            end
         end
         CLEAR: begin
            mac_clear = 1'b1;
            if (len_q == '0) begin
               state_d = DONE;
            end else begin
               rd_en = 1'b1;
               if (len_q == LEN_W'(1)) begin
                  state_d = DRAIN;
               end else begin
                  addr_step = 1'b1;
                  idx_d     = LEN_W'(1);
                  state_d   = RUN;
               end
            end
         end
         RUN: begin
            rd_en      = 1'b1;
            mac_enable = 1'b1;
            if (idx_q == len_q - LEN_W'(1)) begin
               state_d = DRAIN;
            end else begin
               addr_step = 1'b1;
               idx_d     = idx_q + LEN_W'(1);
            end
         end
         DRAIN: begin
            mac_enable = 1'b1;
            state_d    = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (job.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   mac_seq_addr_gen #(.ADDR_W(ADDR_W)) u_w_addr (
      .clk  (clk),
      .rst  (rst),
      .load (addr_load),
      .base (job.cfg_w_base),
      .step (addr_step),
      .addr (w_rd_addr)
   );

   mac_seq_addr_gen #(.ADDR_W(ADDR_W)) u_a_addr (
      .clk  (clk),
      .rst  (rst),
      .load (addr_load),
      .base (job.cfg_a_base),
      .step (addr_step),
      .addr (a_rd_addr)
   );

`ifdef MAC_SEQ_RELU_EN
   assign result_view = relu(mac_result);
`else
   assign result_view = mac_result;
`endif

   assign w_rd_en         = rd_en;
   assign a_rd_en         = rd_en;
   assign job.start_ready = start_ready;
   assign job.out_valid   = out_valid;
   // The MAC is idle in DONE, so the accumulator is stable while presented.
   assign job.out_data    = out_valid ? result_view : '0;
   assign busy            = (state_q != IDLE);

endmodule
